// File: rtl/conv_pkg.sv
// Shared types for the 3x3 convolution datapath: result word and column index.
package conv_pkg;

   localparam int unsigned NumCol   = 8;
   localparam int unsigned OfmWidth = 32;

   typedef logic [OfmWidth-1:0]        sum_t;
   typedef logic [$clog2(NumCol)-1:0]  col_idx_t;

endpackage

// File: rtl/sum_fifo.sv
// Single-clock show-ahead FIFO holding one column's partial sums.
module sum_fifo #(
   parameter int unsigned Width = 32,
   parameter int unsigned Depth = 4
) (
   input  logic             clk_i,
   input  logic             rstn_i,
   input  logic             clr_i,
   input  logic             push_i,
   input  logic [Width-1:0] din_i,
   input  logic             pop_i,
   output logic [Width-1:0] dout_o,
   output logic             empty_o,
   output logic             full_o
);

   localparam int unsigned AddrW = $clog2(Depth);

   logic [AddrW:0]   wr_ptr_q, wr_ptr_d;
   logic [AddrW:0]   rd_ptr_q, rd_ptr_d;
   logic [Width-1:0] mem_q [Depth];
   logic             wr_en, rd_en;

   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
                    (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);

   // A push into a full FIFO is still taken when the head leaves in the same cycle.
   assign wr_en = push_i & (~full_o | pop_i) & ~clr_i;
   assign rd_en = pop_i & ~empty_o & ~clr_i;

   always_comb begin
      wr_ptr_d = wr_ptr_q + (AddrW+1)'(wr_en);
      rd_ptr_d = rd_ptr_q + (AddrW+1)'(rd_en);
      if (clr_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (wr_en) begin
         mem_q[wr_ptr_q[AddrW-1:0]] <= din_i;
      end
   end

   assign dout_o = mem_q[rd_ptr_q[AddrW-1:0]];

endmodule

// File: rtl/ofm_drain_33.sv
// Per-column result buffering with round-robin serialisation onto one tagged
// valid/ready stream, plus overflow flags and end-of-convolution drain pulse.
module ofm_drain_33
   import conv_pkg::*;
#(
   parameter int unsigned COL           = NumCol,
   parameter int unsigned OFM_WIDTH     = OfmWidth,
   parameter int unsigned FIFO_DEPTH    = 4,
   parameter int unsigned COL_IDX_WIDTH = $clog2(COL)
) (
   input  logic                          clk_i,
   input  logic                          rstn_i,
   input  logic                          start_conv_i,
   input  logic [COL-1:0]                sum_valid_i,
   input  logic [COL-1:0][OFM_WIDTH-1:0] sum_i,
   input  logic                          conv_done_i,
   output logic                          out_valid_o,
   input  logic                          out_ready_i,
   output logic [OFM_WIDTH-1:0]          out_data_o,
   output logic [COL_IDX_WIDTH-1:0]      out_col_o,
   output logic                          drain_done_o,
   output logic [COL-1:0]                overflow_o
);

   localparam logic [COL_IDX_WIDTH-1:0] LastCol = COL_IDX_WIDTH'(COL - 1);

   logic [COL-1:0]                fifo_empty, fifo_full, fifo_push, fifo_pop;
   logic [COL-1:0][OFM_WIDTH-1:0] fifo_head;

   logic                     out_valid_q, out_valid_d;
   logic [OFM_WIDTH-1:0]     out_data_q, out_data_d;
   logic [COL_IDX_WIDTH-1:0] out_col_q, out_col_d;
   logic [COL_IDX_WIDTH-1:0] last_grant_q, last_grant_d;
   logic [COL-1:0]           overflow_q, overflow_d;
   logic                     pend_q, pend_d;

   logic                     load, gnt_found, drain_fire;
   logic [COL_IDX_WIDTH-1:0] gnt_idx;

   assign fifo_push = sum_valid_i & {COL{~start_conv_i}};

   for (genvar c = 0; c < COL; c++) begin : g_fifo
      sum_fifo #(
         .Width(OFM_WIDTH),
         .Depth(FIFO_DEPTH)
      ) u_fifo (
         .clk_i  (clk_i),
         .rstn_i (rstn_i),
         .clr_i  (start_conv_i),
         .push_i (fifo_push[c]),
         .din_i  (sum_i[c]),
         .pop_i  (fifo_pop[c]),
         .dout_o (fifo_head[c]),
         .empty_o(fifo_empty[c]),
         .full_o (fifo_full[c])
      );
   end

   assign load = ~out_valid_q | out_ready_i;

   // Round-robin: first non-empty column starting just after the last grant.
   always_comb begin
      int unsigned idx;
      logic [COL_IDX_WIDTH-1:0] cand;
      idx       = 0;
      cand      = '0;
      gnt_found = 1'b0;
      gnt_idx   = '0;
      for (int unsigned i = 0; i < COL; i++) begin
         idx = 32'(last_grant_q) + 1 + i;
         if (idx >= COL) idx = idx - COL;
         cand = COL_IDX_WIDTH'(idx);
         if (!gnt_found && !fifo_empty[cand]) begin
            gnt_found = 1'b1;
            gnt_idx   = cand;
         end
      end
   end

   always_comb begin
      fifo_pop = '0;
      if (load && gnt_found && !start_conv_i) fifo_pop[gnt_idx] = 1'b1;
   end

   // Drain completes when nothing is buffered and the output register is free
   // or handing off its last word this cycle.
   assign drain_fire = pend_q & (&fifo_empty) & load & ~start_conv_i;

   always_comb begin
      out_valid_d  = out_valid_q;
      out_data_d   = out_data_q;
      out_col_d    = out_col_q;
      last_grant_d = last_grant_q;
      overflow_d   = overflow_q;
      pend_d       = pend_q;
      if (start_conv_i) begin
         out_valid_d  = 1'b0;
         last_grant_d = LastCol;
         overflow_d   = '0;
         pend_d       = 1'b0;
      end else begin
         if (load) begin
            out_valid_d = gnt_found;
            if (gnt_found) begin
               out_data_d   = fifo_head[gnt_idx];
               out_col_d    = gnt_idx;
               last_grant_d = gnt_idx;
            end
         end
         overflow_d = overflow_q | (sum_valid_i & fifo_full & ~fifo_pop);
         pend_d     = conv_done_i | (pend_q & ~drain_fire);
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         out_valid_q  <= 1'b0;
         out_data_q   <= '0;
         out_col_q    <= '0;
         last_grant_q <= LastCol;
         overflow_q   <= '0;
         pend_q       <= 1'b0;
      end else begin
         out_valid_q  <= out_valid_d;
         out_data_q   <= out_data_d;
         out_col_q    <= out_col_d;
         last_grant_q <= last_grant_d;
         overflow_q   <= overflow_d;
         pend_q       <= pend_d;
      end
   end

   assign out_valid_o  = out_valid_q;
   assign out_data_o   = out_data_q;
   assign out_col_o    = out_col_q;
   assign overflow_o   = overflow_q;
   assign drain_done_o = drain_fire;

endmodule

// File: tb/tb_ofm_drain_33.sv
// Bench for ofm_drain_33: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_ofm_drain_33;
   import conv_pkg::*;

   localparam int COL   = 8;
   localparam int DEPTH = 4;

   logic                 clk = 1'b0;
   logic                 rstn = 1'b0;
   logic                 start_conv = 1'b0;
   logic                 conv_done = 1'b0;
   logic                 out_ready = 1'b0;
   logic [COL-1:0]       sum_valid = '0;
   sum_t [COL-1:0]       sum_in = '0;
   logic                 out_valid;
   sum_t                 out_data;
   logic [2:0]           out_col;
   logic                 drain_done;
   logic [COL-1:0]       overflow;

   int checks = 0;
   int errors = 0;

   sum_t           mq [COL][$];
   bit             m_valid;
   sum_t           m_data;
   int             m_col;
   int             m_last;
   bit [COL-1:0]   m_ovf;
   bit             m_pend;

   ofm_drain_33 dut (
      .clk_i       (clk),
      .rstn_i      (rstn),
      .start_conv_i(start_conv),
      .sum_valid_i (sum_valid),
      .sum_i       (sum_in),
      .conv_done_i (conv_done),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .out_data_o  (out_data),
      .out_col_o   (out_col),
      .drain_done_o(drain_done),
      .overflow_o  (overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void model_reset();
      for (int c = 0; c < COL; c++) mq[c].delete();
      m_valid = 0;
      m_data  = '0;
      m_col   = 0;
      m_last  = COL - 1;
      m_ovf   = '0;
      m_pend  = 0;
   endfunction

   function automatic bit all_empty();
      for (int c = 0; c < COL; c++) if (mq[c].size() != 0) return 0;
      return 1;
   endfunction

   function automatic bit exp_drain();
      return m_pend && all_empty() && (!m_valid || out_ready) && !start_conv;
   endfunction

   task automatic check_cycle();
      chk("out_valid", 64'(out_valid), 64'(m_valid));
      if (m_valid) begin
         chk("out_data", 64'(out_data), 64'(m_data));
         chk("out_col", 64'(out_col), 64'(m_col));
      end
      chk("drain_done", 64'(drain_done), 64'(exp_drain()));
      chk("overflow", 64'(overflow), 64'(m_ovf));
   endtask

   // Next state from the current inputs: pop the winner first, then accept pushes.
   task automatic model_advance();
      bit d;
      int c;
      d = exp_drain();
      if (start_conv) begin
         model_reset();
         m_data = out_data;
         m_col  = int'(out_col);
      end else begin
         if (!m_valid || out_ready) begin
            m_valid = 0;
            for (int i = 1; i <= COL; i++) begin
               c = (m_last + i) % COL;
               if (mq[c].size() > 0) begin
                  m_data  = mq[c].pop_front();
                  m_col   = c;
                  m_last  = c;
                  m_valid = 1;
                  break;
               end
            end
         end
         for (int k = 0; k < COL; k++) begin
            if (sum_valid[k]) begin
               if (mq[k].size() < DEPTH) mq[k].push_back(sum_in[k]);
               else m_ovf[k] = 1;
            end
         end
         m_pend = conv_done || (m_pend && !d);
      end
   endtask

   task automatic step();
      @(negedge clk);
      check_cycle();
      model_advance();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rstn       = 1'b0;
      sum_valid  = '0;
      conv_done  = 1'b0;
      start_conv = 1'b0;
      #2;
      model_reset();
      chk("rst_valid", 64'(out_valid), 64'd0);
      chk("rst_data", 64'(out_data), 64'd0);
      chk("rst_col", 64'(out_col), 64'd0);
      chk("rst_drain", 64'(drain_done), 64'd0);
      chk("rst_overflow", 64'(overflow), 64'd0);
      @(negedge clk);
      rstn = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      do_reset();
      out_ready  = 1'b1;
      start_conv = 1'b1;
      step();
      start_conv = 1'b0;

      // Single column: visible two cycles after the strobe, for one cycle.
      sum_valid = 8'h01;
      sum_in[0] = 32'h1234;
      step();
      sum_valid = '0;
      step();
      chk("single_valid", 64'(out_valid), 64'd1);
      chk("single_data", 64'(out_data), 64'h1234);
      chk("single_col", 64'(out_col), 64'd0);
      step();
      chk("single_once", 64'(out_valid), 64'd0);

      // All columns in one cycle: eight back-to-back beats in column order.
      start_conv = 1'b1;
      step();
      start_conv = 1'b0;
      for (int c = 0; c < COL; c++) sum_in[c] = sum_t'(100 + c);
      sum_valid = 8'hFF;
      step();
      sum_valid = '0;
      step();
      for (int k = 0; k < COL; k++) begin
         chk("all_valid", 64'(out_valid), 64'd1);
         chk("all_col", 64'(out_col), 64'(k));
         chk("all_data", 64'(out_data), 64'(100 + k));
         step();
      end
      chk("all_end", 64'(out_valid), 64'd0);

      // Backpressure: ten stalled cycles, output held, then in-order delivery.
      start_conv = 1'b1;
      step();
      start_conv = 1'b0;
      out_ready = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (i < 4) begin
            sum_valid = 8'h08;
            sum_in[3] = sum_t'(32'h300 + i);
         end else begin
            sum_valid = '0;
         end
         step();
         if (i >= 1) begin
            chk("bp_hold_valid", 64'(out_valid), 64'd1);
            chk("bp_hold_data", 64'(out_data), 64'h300);
            chk("bp_hold_col", 64'(out_col), 64'd3);
         end
      end
      out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         chk("bp_data", 64'(out_data), 64'(32'h300 + k));
         step();
      end
      chk("bp_overflow", 64'(overflow), 64'd0);

      // Overflow: six pushes into column 5 while stalled; the sixth is lost.
      out_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         sum_valid = 8'h20;
         sum_in[5] = sum_t'(32'h500 + i);
         step();
      end
      sum_valid = '0;
      chk("ovf_flag", 64'(overflow), 64'h20);
      out_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         chk("ovf_valid", 64'(out_valid), 64'd1);
         chk("ovf_data", 64'(out_data), 64'(32'h500 + k));
         step();
      end
      chk("ovf_lost", 64'(out_valid), 64'd0);

      // Drain: three buffered results, pulse on the third handshake only.
      for (int c = 0; c < 3; c++) sum_in[c] = sum_t'(32'h700 + c);
      sum_valid = 8'h07;
      step();
      sum_valid = '0;
      conv_done = 1'b1;
      step();
      conv_done = 1'b0;
      chk("drain_hs1", 64'(drain_done), 64'd0);
      step();
      chk("drain_hs2", 64'(drain_done), 64'd0);
      step();
      chk("drain_hs3", 64'(drain_done), 64'd1);
      chk("drain_hs3_col", 64'(out_col), 64'd2);
      step();
      chk("drain_once", 64'(drain_done), 64'd0);
      start_conv = 1'b1;
      step();
      start_conv = 1'b0;
      chk("clear_overflow", 64'(overflow), 64'd0);

      // Column 2 full, popped and pushed in the same cycle.
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         sum_valid = 8'h04;
         sum_in[2] = sum_t'(32'h200 + i);
         step();
      end
      out_ready = 1'b1;
      sum_in[2] = 32'h205;
      step();
      sum_valid = '0;
      chk("pp_overflow", 64'(overflow), 64'd0);
      for (int k = 1; k <= 5; k++) begin
         chk("pp_data", 64'(out_data), 64'(32'h200 + k));
         step();
      end

      // Randomized traffic with varying backpressure and one mid-stream reset.
      for (int n = 0; n < 4000; n++) begin
         int rdy_pct;
         rdy_pct = ((n / 200) % 3 == 0) ? 30 : 85;
         if (n == 2000) do_reset();
         sum_valid  = COL'($urandom & $urandom);
         for (int c = 0; c < COL; c++) sum_in[c] = $urandom;
         out_ready  = ($urandom_range(0, 99) < rdy_pct);
         conv_done  = ($urandom_range(0, 30) == 0);
         start_conv = ($urandom_range(0, 300) == 0);
         step();
      end
      sum_valid  = '0;
      conv_done  = 1'b0;
      start_conv = 1'b0;
      out_ready  = 1'b1;
      for (int n = 0; n < 40; n++) step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
